// File: rtl/full_adder_cell.sv
// Single-bit full adder: purely combinational sum and carry of three input bits.
// The carry reuses the a^b term so the sum and carry share one XOR.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign s     = w_axb ^ cin;
    assign cout  = (a & b) | (cin & w_axb);

endmodule

// File: rtl/top.sv
// One-bit adder wrapper: a full_adder_cell whose outputs are either wired straight
// through (OUT_REG=0) or captured in a 2-bit register with synchronous reset (OUT_REG=1).
module top #(
    parameter bit OUT_REG = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_s;
    logic w_cout;

    full_adder_cell u_cell (
        .a    (a),
        .b    (b),
        .cin  (cin),
        .s    (w_s),
        .cout (w_cout)
    );

    generate
        if (OUT_REG == 1'b1) begin : g_reg
            logic [1:0] r_sum;

            // Output register: reset clears both bits, otherwise capture {cout,s}
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sum <= 2'b00;
                end else begin
                    r_sum <= {w_cout, w_s};
                end
            end

            assign cout = r_sum[1];
            assign s    = r_sum[0];
        end else begin : g_comb
            // clk and rst play no part in the combinational variant
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst};

            assign s    = w_s;
            assign cout = w_cout;
        end
    endgenerate

endmodule

// File: tb/tb_top.sv
// Directed bench for top: one combinational and one registered instance share the inputs.
module tb_top;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a   = 1'b0;
    logic b   = 1'b0;
    logic cin = 1'b0;
    logic s_c, cout_c;
    logic s_r, cout_r;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    top #(.OUT_REG(1'b0)) u_comb (
        .clk (clk), .rst (rst), .a (a), .b (b), .cin (cin), .s (s_c), .cout (cout_c)
    );

    top #(.OUT_REG(1'b1)) u_reg (
        .clk (clk), .rst (rst), .a (a), .b (b), .cin (cin), .s (s_r), .cout (cout_r)
    );

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] tbl [8];
        logic [2:0] v;
        logic [1:0] ref_sum;
        tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        // Reset state of the registered instance
        @(posedge clk); #1;
        check("reg_reset_state", {cout_r, s_r}, 2'b00);

        // Combinational truth table, {b,a,cin} = 0..7
        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            {b, a, cin} = v;
            #1;
            check($sformatf("comb_tt_%0d", i), {cout_c, s_c}, tbl[i]);
        end

        // Combinational output ignores clk and rst
        a = 1'b1; b = 1'b1; cin = 1'b0; rst = 1'b0;
        #1;
        check("comb_110", {cout_c, s_c}, 2'b10);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("comb_rst_hi", {cout_c, s_c}, 2'b10);
        rst = 1'b0;
        @(posedge clk); #1;
        check("comb_rst_lo", {cout_c, s_c}, 2'b10);

        // Registered: reset held for two edges with all inputs high
        @(negedge clk);
        rst = 1'b1; a = 1'b1; b = 1'b1; cin = 1'b1;
        @(posedge clk); #1;
        check("reg_rst_edge1", {cout_r, s_r}, 2'b00);
        @(posedge clk); #1;
        check("reg_rst_edge2", {cout_r, s_r}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reg_release_111", {cout_r, s_r}, 2'b11);

        // Mid-cycle input change holds until the next edge
        #2;
        a = 1'b1; b = 1'b0; cin = 1'b0;
        #1;
        check("reg_hold_midcycle", {cout_r, s_r}, 2'b11);
        check("comb_midcycle", {cout_c, s_c}, 2'b01);
        @(posedge clk); #1;
        check("reg_after_change", {cout_r, s_r}, 2'b01);

        // Reset pulse mid-stream of a=b=1, cin=0
        @(negedge clk);
        a = 1'b1; b = 1'b1; cin = 1'b0;
        @(posedge clk); #1;
        check("reg_stream_110", {cout_r, s_r}, 2'b10);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("reg_midstream_rst", {cout_r, s_r}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reg_after_rst_pulse", {cout_r, s_r}, 2'b10);

        // Exhaustive sweep of both instances against a+b+cin
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            v = i[2:0];
            {b, a, cin} = v;
            ref_sum = 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
            #1;
            check($sformatf("comb_sweep_%0d", i), {cout_c, s_c}, ref_sum);
            @(posedge clk); #1;
            check($sformatf("reg_sweep_%0d", i), {cout_r, s_r}, ref_sum);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
